// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared constants and types for the fetch front end.
//   XLEN          : datapath width
//   NOP_INSN      : canonical NOP (addi x0, x0, 0) used for IF/ID bubbles
//   fetch_state_t : REQ  - nothing outstanding
//                   WAIT - one request outstanding, response will be kept
//                   DROP - one request outstanding, response will be discarded
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding buffer for an instruction response that arrives while the
// IF/ID register is stalled. Holds the instruction word, its PC and a valid bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : capture i_ins/i_pc and mark the entry valid
//   i_pop      : entry consumed by IF/ID, mark it empty
//   i_clear    : discard the entry (redirect); wins over push and pop
//   i_ins/i_pc : response word and its fetch PC
//   o_valid    : entry holds an unconsumed response
//   o_ins/o_pc : buffered word and PC
// -----------------------------------------------------------------------------
module fetch_skid_buf
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_ins,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_ins,
    output logic [XLEN-1:0] o_pc
);

    logic            r_valid;
    logic [XLEN-1:0] r_ins;
    logic [XLEN-1:0] r_pc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_push) begin
            r_valid <= 1'b1;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    // NOTE: the payload is qualified by r_valid and could skip reset, but it is
    // a single entry, so it is reset to keep the outputs free of X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ins <= NOP_INSN;
            r_pc  <= '0;
        end else if (i_push) begin
            r_ins <= i_ins;
            r_pc  <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_ins   = r_ins;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch with at most one outstanding memory request, a one-entry
// skid buffer for responses that arrive during a stall, and the IF/ID register.
//   RESET_PC                       : first fetch address after reset
//   clk, rst_n                     : clock, asynchronous active-low reset
//   stall_i                        : hold IF/ID
//   flush_i                        : bubble IF/ID only
//   redirect_valid_i/redirect_pc_i : taken branch/jump from EX (target bits [1:0] ignored)
//   imem_req_o/imem_addr_o         : fetch request and address (address = pc_q)
//   imem_gnt_i                     : request accepted this cycle
//   imem_rvalid_i/imem_rdata_i     : response, exactly one cycle after the grant
//   ins_o/pc_o/valid_o             : IF/ID instruction, its PC, and valid flag
// -----------------------------------------------------------------------------
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] ins_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_ins;
    logic [XLEN-1:0] r_pc_id;
    logic            r_valid;

    logic            w_req;
    logic            w_grant;
    logic            w_rsp_keep;
    logic            w_skid_push;
    logic            w_skid_pop;
    logic            w_skid_valid;
    logic [XLEN-1:0] w_skid_ins;
    logic [XLEN-1:0] w_skid_pc;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_unused_lsbs;

    // Targets are word aligned; the low two bits are deliberately dropped.
    assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign w_unused_lsbs = ^redirect_pc_i[1:0];

    // A response that belongs to the current program flow.
    assign w_rsp_keep = (r_state == WAIT) && imem_rvalid_i;

    // A kept response that cannot enter IF/ID goes to the skid buffer.
    assign w_skid_push = w_rsp_keep && stall_i && !redirect_valid_i;
    assign w_skid_pop  = w_skid_valid && !stall_i && !flush_i && !redirect_valid_i;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_req       = 1'b0;
        w_grant     = 1'b0;
        w_state_nxt = r_state;

        // A new request may overlap only the cycle its predecessor completes;
        // rst_n gates it so nothing is requested while reset is held.
        w_req   = rst_n && !w_skid_valid && !redirect_valid_i &&
                  ((r_state == REQ) || (w_rsp_keep && !stall_i));
        w_grant = w_req && imem_gnt_i;

        if (redirect_valid_i) begin
            // A response still owed by memory must be swallowed in DROP.
            if ((r_state != REQ) && !imem_rvalid_i) begin
                w_state_nxt = DROP;
            end else begin
                w_state_nxt = REQ;
            end
        end else if (w_grant) begin
            w_state_nxt = WAIT;
        end else if ((r_state != REQ) && imem_rvalid_i) begin
            w_state_nxt = REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else if (redirect_valid_i) begin
            r_pc <= w_redirect_pc;
        end else if (w_grant) begin
            r_pc     <= r_pc + 32'd4;
            r_req_pc <= r_pc;
        end
    end

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_skid_push),
        .i_pop   (w_skid_pop),
        .i_clear (redirect_valid_i),
        .i_ins   (imem_rdata_i),
        .i_pc    (r_req_pc),
        .o_valid (w_skid_valid),
        .o_ins   (w_skid_ins),
        .o_pc    (w_skid_pc)
    );

    // IF/ID: squash beats stall; a buffered response is older than any new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ins   <= NOP_INSN;
            r_pc_id <= '0;
        end else if (flush_i || redirect_valid_i) begin
            r_valid <= 1'b0;
            r_ins   <= NOP_INSN;
            r_pc_id <= '0;
        end else if (stall_i) begin
            r_valid <= r_valid;
        end else if (w_skid_valid) begin
            r_valid <= 1'b1;
            r_ins   <= w_skid_ins;
            r_pc_id <= w_skid_pc;
        end else if (w_rsp_keep) begin
            r_valid <= 1'b1;
            r_ins   <= imem_rdata_i;
            r_pc_id <= r_req_pc;
        end else begin
            r_valid <= 1'b0;
            r_ins   <= NOP_INSN;
            r_pc_id <= '0;
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc;
    assign ins_o       = r_ins;
    assign pc_o        = r_pc_id;
    assign valid_o     = r_valid;

endmodule
